pc_fetch_unit: RTL

Program-counter stage directly upstream of the instruction memory in the single-cycle MIPS datapath. Holds the PC and computes next-PC from sequential, branch, jump and jump-register sources. Supports stall and halt, and exports the word index for instruction memory. Keeps a retired-instruction counter and a sticky misalignment flag for debug.

---
 rtl/pc_fetch_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter stage feeding the instruction memory of a single-cycle
//   MIPS datapath. Holds the PC, selects next-PC (jr > jump > taken branch >
//   sequential), and tracks the BOOT/RUN/STALL/HALT sequencing. It also keeps a
//   retired-instruction counter and a sticky flag for a misaligned jr target.
//
// Ports
//   clk, reset    rising-edge clock, async active-high reset
//   stall, halt   pipeline hold / terminate for the current instruction
//   branch, zero  conditional branch and its ALU resolution
//   jump, jr      unconditional j/jal and register-indirect jump
//   immediate     signed branch offset in words
//   taradd        26-bit jump target field
//   jr_target     register value used by jr
//   pc            current PC (byte address)
//   pc_plus4      pc + 4 (link value)
//   imem_addr     word index into instruction memory, pc[IMEM_AW+1:2]
//   fetch_valid   pc holds an instruction to execute (RUN or STALL)
//   halted        unit is in HALT
//   misalign      sticky: a jr was taken to a non-word-aligned target
//   inst_count    retired instruction count (wraps at 2^32)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_AW      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               halt,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  input  logic               jr,
  input  logic [15:0]        immediate,
  input  logic [25:0]        taradd,
  input  logic [31:0]        jr_target,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               fetch_valid,
  output logic               halted,
  output logic               misalign,
  output logic [31:0]        inst_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;

  logic [31:0] seq_pc, br_off, next_pc;

  assign seq_pc = pc_q + 32'd4;
  // Word offset sign-extended and scaled to bytes.
  assign br_off = {{14{immediate[15]}}, immediate, 2'b00};

  always_comb begin
    next_pc = seq_pc;
    if (jr)                 next_pc = {jr_target[31:2], 2'b00};
    else if (jump)          next_pc = {seq_pc[31:28], taradd, 2'b00};
    else if (branch & zero) next_pc = seq_pc + br_off;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (halt) begin
          // The halt instruction itself retires; pc stays on it.
          state_d = S_HALT;
          cnt_d   = cnt_q + 32'd1;
        end else if (stall) begin
          state_d = S_STALL;
        end else begin
          pc_d  = next_pc;
          cnt_d = cnt_q + 32'd1;
          if (jr && (jr_target[1:0] != 2'b00)) mis_d = 1'b1;
        end
      end
      // Release returns to RUN without advancing; the following edge is a
      // normal RUN evaluation. halt is not seen while held here.
      S_STALL: if (!stall) state_d = S_RUN;
      S_HALT:  ;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;
  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign fetch_valid = (state_q == S_RUN) || (state_q == S_STALL);
  assign halted      = (state_q == S_HALT);
  assign misalign    = mis_q;
  assign inst_count  = cnt_q;

endmodule
